in_reg_bank: RTL and testbench



---
 rtl/in_reg_bank_if.sv | 29 ++
 rtl/in_reg_bank.sv | 98 +++++++++
 tb/tb_in_reg_bank.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/in_reg_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : in_reg_bank_if
// Brief    : Pad-side / fabric-side signal bundle for the input register bank.
// Revision : 1.0  initial release
// ============================================================================
interface in_reg_bank_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] A2F;
    logic [WIDTH-1:0] ISEL;
    logic [WIDTH-1:0] FIXHOLD;
    logic             IQE;
    logic             CHG_ACK;
    logic [WIDTH-1:0] IQZ;
    logic [WIDTH-1:0] CHG_MASK;
    logic             CHG_IRQ;

    modport slave (
        input  A2F, ISEL, FIXHOLD, IQE, CHG_ACK,
        output IQZ, CHG_MASK, CHG_IRQ
    );

    modport master (
        output A2F, ISEL, FIXHOLD, IQE, CHG_ACK,
        input  IQZ, CHG_MASK, CHG_IRQ
    );
endinterface
`default_nettype wire

// File: rtl/in_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : in_reg_bank
// Brief    : Multi-channel pad input register with optional extra sync stage,
//            per-channel glitch filter, raw bypass and sticky change detect.
// Revision : 1.0  initial release
// ============================================================================
module in_reg_bank #(
    parameter int WIDTH    = 8,
    parameter int FILT_CNT = 0
) (
    input  logic          IQC,
    input  logic          QRT,
    in_reg_bank_if.slave  bus
);

    logic [WIDTH-1:0] s0_q, s1_q;
    logic [WIDTH-1:0] synced;
    logic [WIDTH-1:0] filt, filt_d;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             irq_q;

    always_ff @(posedge IQC or posedge QRT) begin
        if (QRT) begin
            s0_q <= '0;
            s1_q <= '0;
        end else if (bus.IQE) begin
            s0_q <= bus.A2F;
            s1_q <= s0_q;
        end
    end

    assign synced = (bus.FIXHOLD & s1_q) | (~bus.FIXHOLD & s0_q);

    if (FILT_CNT == 0) begin : g_nofilt
        // Without a filter the value after the edge is what synced will become.
        assign filt   = synced;
        assign filt_d = bus.IQE ? ((bus.FIXHOLD & s0_q) | (~bus.FIXHOLD & bus.A2F))
                                : synced;
    end else begin : g_filt
        localparam int              c_CW   = $clog2(FILT_CNT + 1);
        localparam logic [c_CW-1:0] c_LAST = c_CW'(FILT_CNT - 1);

        for (genvar i = 0; i < WIDTH; i++) begin : g_ch
            logic [c_CW-1:0] cnt_q, cnt_d;
            logic            f_q, f_d;

            always_comb begin
                cnt_d = cnt_q;
                f_d   = f_q;
                if (bus.IQE) begin
                    if (synced[i] == f_q) begin
                        cnt_d = '0;
                    end else if (cnt_q == c_LAST) begin
                        f_d   = synced[i];
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge IQC or posedge QRT) begin
                if (QRT) begin
                    cnt_q <= '0;
                    f_q   <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    f_q   <= f_d;
                end
            end

            assign filt[i]   = f_q;
            assign filt_d[i] = f_d;
        end
    end

    // An ack on the same edge as a fresh toggle keeps only the fresh bits.
    assign toggle = filt_d ^ filt;
    assign mask_d = (bus.CHG_ACK ? '0 : mask_q) | toggle;

    always_ff @(posedge IQC or posedge QRT) begin
        if (QRT) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            irq_q  <= |mask_d;
        end
    end

    assign bus.IQZ      = (bus.ISEL & bus.A2F) | (~bus.ISEL & filt);
    assign bus.CHG_MASK = mask_q;
    assign bus.CHG_IRQ  = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_in_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_in_reg_bank
// Brief    : Directed bench for in_reg_bank with FILT_CNT = 0, 3 and 2.
// Revision : 1.0  initial release
// ============================================================================
module tb_in_reg_bank;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    in_reg_bank_if #(.WIDTH(8)) if0 ();
    in_reg_bank_if #(.WIDTH(8)) if3 ();
    in_reg_bank_if #(.WIDTH(8)) if2 ();

    in_reg_bank #(.WIDTH(8), .FILT_CNT(0)) u_dut0 (.IQC(clk), .QRT(rst), .bus(if0));
    in_reg_bank #(.WIDTH(8), .FILT_CNT(3)) u_dut3 (.IQC(clk), .QRT(rst), .bus(if3));
    in_reg_bank #(.WIDTH(8), .FILT_CNT(2)) u_dut2 (.IQC(clk), .QRT(rst), .bus(if2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        if0.A2F = 8'hA5; if0.ISEL = 8'h0F; if0.FIXHOLD = '0; if0.IQE = 1'b1; if0.CHG_ACK = 1'b0;
        if3.A2F = '0;    if3.ISEL = '0;    if3.FIXHOLD = '0; if3.IQE = 1'b1; if3.CHG_ACK = 1'b0;
        if2.A2F = '0;    if2.ISEL = '0;    if2.FIXHOLD = '0; if2.IQE = 1'b1; if2.CHG_ACK = 1'b0;

        // Reset with bypass on the low nibble
        #1;
        chk("rst_iqz_bypass", 32'(if0.IQZ), 32'h05);
        chk("rst_mask",       32'(if0.CHG_MASK), 32'h00);
        chk("rst_irq",        32'(if0.CHG_IRQ), 32'h0);
        tick();
        tick();
        chk("rst_hold_iqz",   32'(if0.IQZ), 32'h05);
        rst = 1'b0;
        if0.ISEL = '0;
        if0.A2F  = 8'h3C;
        #1;
        chk("rel_iqz_pre",    32'(if0.IQZ), 32'h00);
        tick();
        chk("cap_iqz",        32'(if0.IQZ), 32'h3C);
        chk("cap_mask",       32'(if0.CHG_MASK), 32'h3C);
        chk("cap_irq",        32'(if0.CHG_IRQ), 32'h1);

        if0.CHG_ACK = 1'b1;
        tick();
        chk("ack_mask",       32'(if0.CHG_MASK), 32'h00);
        chk("ack_irq",        32'(if0.CHG_IRQ), 32'h0);
        if0.CHG_ACK = 1'b0;

        // FIXHOLD latency on the upper nibble
        if0.A2F = 8'h00;
        tick();
        chk("clr_mask",       32'(if0.CHG_MASK), 32'h3C);
        if0.CHG_ACK = 1'b1;
        tick();
        chk("clr_ack",        32'(if0.CHG_MASK), 32'h00);
        if0.CHG_ACK = 1'b0;
        if0.FIXHOLD = 8'hF0;
        if0.A2F     = 8'hFF;
        tick();
        chk("fh_e1_iqz",      32'(if0.IQZ), 32'h0F);
        chk("fh_e1_mask",     32'(if0.CHG_MASK), 32'h0F);
        tick();
        chk("fh_e2_iqz",      32'(if0.IQZ), 32'hFF);
        chk("fh_e2_mask",     32'(if0.CHG_MASK), 32'hFF);

        // Ack collision
        if0.FIXHOLD = 8'h00;
        if0.CHG_ACK = 1'b1;
        tick();
        chk("col_clear",      32'(if0.CHG_MASK), 32'h00);
        if0.CHG_ACK = 1'b0;
        if0.A2F     = 8'hFE;
        tick();
        chk("col_m01",        32'(if0.CHG_MASK), 32'h01);
        if0.CHG_ACK = 1'b1;
        if0.A2F     = 8'hFC;
        tick();
        chk("col_m02",        32'(if0.CHG_MASK), 32'h02);
        chk("col_irq1",       32'(if0.CHG_IRQ), 32'h1);
        tick();
        chk("col_m00",        32'(if0.CHG_MASK), 32'h00);
        chk("col_irq0",       32'(if0.CHG_IRQ), 32'h0);
        if0.CHG_ACK = 1'b0;

        // Zero-latency bypass, pipeline keeps tracking underneath
        if0.ISEL = 8'hFF;
        if0.A2F  = 8'h5A;
        #1;
        chk("byp_iqz",        32'(if0.IQZ), 32'h5A);
        tick();
        if0.ISEL = 8'h00;
        #1;
        chk("byp_track",      32'(if0.IQZ), 32'h5A);

        // Filter N=3: 2-cycle pulse is rejected
        if3.A2F = 8'h01;
        tick();
        tick();
        if3.A2F = 8'h00;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("pulse_iqz_%0d", k), 32'(if3.IQZ), 32'h00);
        end
        chk("pulse_mask",     32'(if3.CHG_MASK), 32'h00);

        // Filter N=3: steady high lands on edge 4
        if3.A2F = 8'h01;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("hold_iqz_e%0d", k), 32'(if3.IQZ), 32'h00);
        end
        tick();
        chk("hold_iqz_e4",    32'(if3.IQZ), 32'h01);
        chk("hold_mask_e4",   32'(if3.CHG_MASK), 32'h01);
        chk("hold_irq_e4",    32'(if3.CHG_IRQ), 32'h1);

        // Return to 0, then high 2 / low 1 / high 3
        if3.A2F = 8'h00;
        for (int k = 0; k < 4; k++) tick();
        chk("ret_iqz",        32'(if3.IQZ), 32'h00);
        if3.CHG_ACK = 1'b1;
        tick();
        if3.CHG_ACK = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            logic [7:0] pat;
            pat     = 8'b0111011;
            if3.A2F = {7'b0, pat[k-1]};
            tick();
            chk($sformatf("pat_iqz_k%0d", k), 32'(if3.IQZ), (k == 7) ? 32'h01 : 32'h00);
        end

        // Async reset with count in flight and IRQ pending
        tick();
        tick();
        chk("pre_rst_iqz",    32'(if3.IQZ), 32'h01);
        chk("pre_rst_irq",    32'(if3.CHG_IRQ), 32'h1);
        rst = 1'b1;
        #2;
        chk("arst_iqz",       32'(if3.IQZ), 32'h00);
        chk("arst_mask",      32'(if3.CHG_MASK), 32'h00);
        chk("arst_irq",       32'(if3.CHG_IRQ), 32'h0);
        rst = 1'b0;
        if3.A2F = 8'h01;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("post_rst_e%0d", k), 32'(if3.IQZ), 32'h00);
        end
        tick();
        chk("post_rst_e4",    32'(if3.IQZ), 32'h01);

        // Filter N=2: IQE low freezes a half-finished count
        if2.A2F = 8'h01;
        tick();
        tick();
        chk("iqe_pre",        32'(if2.IQZ), 32'h00);
        if2.IQE = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("iqe_hold_%0d", k), 32'(if2.IQZ), 32'h00);
        end
        chk("iqe_hold_mask",  32'(if2.CHG_MASK), 32'h00);
        if2.IQE = 1'b1;
        tick();
        chk("iqe_resume_iqz", 32'(if2.IQZ), 32'h01);
        chk("iqe_resume_msk", 32'(if2.CHG_MASK), 32'h01);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
